// File: rtl/led_strip_driver.sv
// WS2812B LED strip driver: each start sends the NUM_LEDS x 24-bit GRB pixel buffer as one frame.
// Optional macro LED_BRIGHTNESS_EN adds input bright[7:0], which scales each channel when a pixel is loaded.
module led_strip_driver #(
  parameter int unsigned NUM_LEDS = 64,
  parameter int unsigned T0H_CYC  = 16,
  parameter int unsigned T0L_CYC  = 34,
  parameter int unsigned T1H_CYC  = 32,
  parameter int unsigned T1L_CYC  = 18,
  parameter int unsigned RES_CYC  = 2000,
  localparam int unsigned AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          start,
`ifdef LED_BRIGHTNESS_EN
  input  logic [7:0]    bright,
`endif
  output logic          busy,
  output logic          done,
  output logic          dout
);

  localparam int unsigned MAX_H  = (T0H_CYC > T1H_CYC) ? T0H_CYC : T1H_CYC;
  localparam int unsigned MAX_L  = (T0L_CYC > T1L_CYC) ? T0L_CYC : T1L_CYC;
  localparam int unsigned MAX_HL = (MAX_H > MAX_L) ? MAX_H : MAX_L;
  localparam int unsigned MAX_T  = (MAX_HL > RES_CYC) ? MAX_HL : RES_CYC;
  localparam int unsigned CW     = $clog2(MAX_T + 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [23:0]     shift, shift_n;
  logic [4:0]      bit_idx, bit_n;
  logic [AW-1:0]   pix_idx, pix_n;
  logic            done_n;

  logic [23:0]     pix_mem [NUM_LEDS];
  logic [AW-1:0]   rd_addr;
  logic [23:0]     rd_pix;
  logic [23:0]     load_pix;
  logic            hi_last;
  logic            lo_last;
  logic            last_pix;

  // Pixel buffer: never reset, out-of-range addresses dropped, reset blocks writes
  always_ff @(posedge clk) begin
    if (!reset && wr_en && (32'(wr_addr) < NUM_LEDS)) begin
      pix_mem[wr_addr] <= wr_data;
    end
  end

  // Single read port: pixel 0 while idle, otherwise the pixel that follows the one on the wire
  assign last_pix = (pix_idx == AW'(NUM_LEDS - 1));
  assign rd_addr  = ((state == IDLE) || last_pix) ? '0 : pix_idx + AW'(1);
  assign rd_pix   = pix_mem[rd_addr];

`ifdef LED_BRIGHTNESS_EN
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    return 8'((16'(c) * (16'(b) + 16'd1)) >> 8);
  endfunction

  assign load_pix = {scale_ch(rd_pix[23:16], bright),
                     scale_ch(rd_pix[15:8],  bright),
                     scale_ch(rd_pix[7:0],   bright)};
`else
  assign load_pix = rd_pix;
`endif

  // The bit on the wire is always shift[23]; it selects the high and low times
  assign hi_last = (cnt == (shift[23] ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1)));
  assign lo_last = (cnt == (shift[23] ? CW'(T1L_CYC - 1) : CW'(T0L_CYC - 1)));

  // State and datapath registers; outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_idx <= '0;
      pix_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shift   <= shift_n;
      bit_idx <= bit_n;
      pix_idx <= pix_n;
      busy    <= (state_n != IDLE);
      done    <= done_n;
      dout    <= (state_n == HIGH);
    end
  end

  // Next-state: bit timing, bit/pixel sequencing and the latch gap
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    bit_n   = bit_idx;
    pix_n   = pix_idx;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = HIGH;
          cnt_n   = '0;
          shift_n = load_pix;
          bit_n   = 5'd23;
          pix_n   = '0;
        end
      end
      HIGH: begin
        if (hi_last) begin
          state_n = LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LOW: begin
        if (lo_last) begin
          cnt_n   = '0;
          state_n = HIGH;
          if (bit_idx != 5'd0) begin
            shift_n = {shift[22:0], 1'b0};
            bit_n   = bit_idx - 5'd1;
          end else if (last_pix) begin
            state_n = LATCH;
          end else begin
            // Next pixel is sampled here, so later buffer writes wait for the next frame
            shift_n = load_pix;
            bit_n   = 5'd23;
            pix_n   = pix_idx + AW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LATCH: begin
        if (cnt == CW'(RES_CYC - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_strip_driver.sv
// Directed self-checking bench for led_strip_driver using three instances: a 1-pixel strip,
// a 64-pixel strip with default timing, and a 3-pixel strip with shortened timing.
module tb_led_strip_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

`ifdef LED_BRIGHTNESS_EN
  logic [7:0] bright;
`endif

  logic        one_reset, one_wr_en, one_start, one_busy, one_done, one_dout;
  logic [0:0]  one_wr_addr;
  logic [23:0] one_wr_data;

  logic        big_reset, big_wr_en, big_start, big_busy, big_done, big_dout;
  logic [5:0]  big_wr_addr;
  logic [23:0] big_wr_data;

  logic        fast_reset, fast_wr_en, fast_start, fast_busy, fast_done, fast_dout;
  logic [1:0]  fast_wr_addr;
  logic [23:0] fast_wr_data;

  led_strip_driver #(.NUM_LEDS(1)) u_one (
    .clk(clk), .reset(one_reset), .wr_en(one_wr_en), .wr_addr(one_wr_addr),
    .wr_data(one_wr_data), .start(one_start),
`ifdef LED_BRIGHTNESS_EN
    .bright(bright),
`endif
    .busy(one_busy), .done(one_done), .dout(one_dout)
  );

  led_strip_driver #(.NUM_LEDS(64)) u_big (
    .clk(clk), .reset(big_reset), .wr_en(big_wr_en), .wr_addr(big_wr_addr),
    .wr_data(big_wr_data), .start(big_start),
`ifdef LED_BRIGHTNESS_EN
    .bright(bright),
`endif
    .busy(big_busy), .done(big_done), .dout(big_dout)
  );

  led_strip_driver #(.NUM_LEDS(3), .T0H_CYC(2), .T0L_CYC(4), .T1H_CYC(4), .T1L_CYC(2),
                     .RES_CYC(10)) u_fast (
    .clk(clk), .reset(fast_reset), .wr_en(fast_wr_en), .wr_addr(fast_wr_addr),
    .wr_data(fast_wr_data), .start(fast_start),
`ifdef LED_BRIGHTNESS_EN
    .bright(bright),
`endif
    .busy(fast_busy), .done(fast_done), .dout(fast_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected dout of the 1-pixel strip holding 24'h800000, k cycles after start was sampled
  function automatic logic one_exp(input int k);
    if (k >= 1200) return 1'b0;
    return (k % 50) < ((k < 50) ? 32 : 16);
  endfunction

  // Runs one frame on the 3-pixel strip, decoding bits from high widths; optional mid-frame writes
  task automatic run_fast(input bit inj, output logic [71:0] bits, output int dk, output int bad);
    int   run, low, nb, rises;
    logic prev, lastb;
    bits = '0; dk = -1; bad = 0; run = 0; low = 0; nb = 0; rises = 0; prev = 1'b0; lastb = 1'b0;
    fast_start = 1'b1;
    tick();
    fast_start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (k > 0) tick();
      fast_wr_en = 1'b0;
      if (fast_dout && !prev) begin
        if (nb > 0 && low != (lastb ? 2 : 4)) bad++;
        rises++;
        run = 0;
        if (inj && rises == 11) begin
          fast_wr_en = 1'b1; fast_wr_addr = 2'd1; fast_wr_data = 24'hFFFFFF;
        end
        if (inj && rises == 12) begin
          fast_wr_en = 1'b1; fast_wr_addr = 2'd0; fast_wr_data = 24'h00FF00;
        end
      end
      if (fast_dout) run++;
      if (!fast_dout && prev) begin
        lastb = (run == 4);
        if (run != 2 && run != 4) bad++;
        if (nb < 72) bits[71 - nb] = lastb;
        nb++;
        low = 0;
      end
      if (!fast_dout) low++;
      prev = fast_dout;
      if (fast_done) begin
        dk = k;
        break;
      end
    end
    if (nb != 72) bad++;
    fast_wr_en = 1'b0;
  endtask

  int          wave_err, one_dk, one_dn, big_dn, big_dk, hi_total, first_hi, dk, bad;
  logic        one_busy_pre, big_busy_pre, busy_at_done;
  logic [2:0]  big_post;
  logic [71:0] bits;

  initial begin
    one_reset = 1'b1; big_reset = 1'b1; fast_reset = 1'b1;
    one_wr_en = 1'b0; big_wr_en = 1'b0; fast_wr_en = 1'b0;
    one_start = 1'b0; big_start = 1'b0; fast_start = 1'b0;
    one_wr_addr = '0; big_wr_addr = '0; fast_wr_addr = '0;
    one_wr_data = '0; big_wr_data = '0; fast_wr_data = '0;
`ifdef LED_BRIGHTNESS_EN
    bright = 8'hFF;
`endif
    repeat (3) tick();
    check("reset_one", 72'({one_dout, one_busy, one_done}), 72'(3'b000));
    check("reset_big", 72'({big_dout, big_busy, big_done}), 72'(3'b000));
    check("reset_fast", 72'({fast_dout, fast_busy, fast_done}), 72'(3'b000));
    one_reset = 1'b0; big_reset = 1'b0; fast_reset = 1'b0;

    // Buffer contents
    one_wr_en = 1'b1; one_wr_addr = 1'b0; one_wr_data = 24'h800000;
    fast_wr_en = 1'b1; fast_wr_addr = 2'd0; fast_wr_data = 24'hA50F3C;
    tick();
    one_wr_en = 1'b0;
    fast_wr_addr = 2'd1; fast_wr_data = 24'h000000;
    tick();
    fast_wr_addr = 2'd2; fast_wr_data = 24'h123456;
    tick();
    fast_wr_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      big_wr_en = 1'b1; big_wr_addr = 6'(i); big_wr_data = 24'h000000;
      tick();
    end
    big_wr_en = 1'b0;

    // 1-pixel waveform alongside a 64-pixel frame that is reset at cycle 5000
    wave_err = 0; one_dn = 0; one_dk = -1; big_dn = 0;
    one_busy_pre = 1'b0; big_busy_pre = 1'b0; big_post = 3'b111;
    one_start = 1'b1; big_start = 1'b1;
    tick();
    one_start = 1'b0; big_start = 1'b0;
    for (int k = 0; k <= 5001; k++) begin
      if (k > 0) tick();
      if (k <= 3210) begin
        if (one_dout !== one_exp(k)) wave_err++;
        if (one_done === 1'b1) begin one_dn++; one_dk = k; end
      end
      if (k == 3199) one_busy_pre = one_busy;
      if (big_done === 1'b1) big_dn++;
      if (k == 4999) begin big_busy_pre = big_busy; big_reset = 1'b1; end
      if (k == 5000) begin big_post = {big_dout, big_busy, big_done}; big_reset = 1'b0; end
    end
    check("one_wave_errors", 72'(wave_err), 72'(0));
    check("one_done_cycle", 72'(one_dk), 72'(3200));
    check("one_done_count", 72'(one_dn), 72'(1));
    check("one_busy_in_latch", 72'(one_busy_pre), 72'(1));
    check("big_busy_before_reset", 72'(big_busy_pre), 72'(1));
    check("big_after_reset", 72'(big_post), 72'(3'b000));
    check("big_no_done_aborted", 72'(big_dn), 72'(0));

    // Full 64-pixel frame with start re-pulsed at cycles 100 and 78790
    big_dn = 0; big_dk = -1; hi_total = 0; first_hi = 0;
    big_busy_pre = 1'b0; busy_at_done = 1'b1;
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    for (int k = 0; k <= 78810; k++) begin
      if (k > 0) tick();
      big_start = (k == 99) || (k == 78789);
      if (big_dout === 1'b1) begin
        hi_total++;
        if (k < 50) first_hi++;
      end
      if (big_done === 1'b1) begin
        big_dn++;
        if (big_dk < 0) big_dk = k;
      end
      if (k == 78799) big_busy_pre = big_busy;
      if (k == 78800) busy_at_done = big_busy;
    end
    big_start = 1'b0;
    check("big_done_cycle", 72'(big_dk), 72'(78800));
    check("big_done_count", 72'(big_dn), 72'(1));
    check("big_high_total", 72'(hi_total), 72'(64 * 24 * 16));
    check("big_first_bit_high", 72'(first_hi), 72'(16));
    check("big_busy_last_latch", 72'(big_busy_pre), 72'(1));
    check("big_busy_at_done", 72'(busy_at_done), 72'(0));

    // Short-timing strip: writes during pixel 0 bit 10/11, then frame decode
    run_fast(1'b1, bits, dk, bad);
    check("fast1_pixels", bits, {24'hA50F3C, 24'hFFFFFF, 24'h123456});
    check("fast1_done_cycle", 72'(dk), 72'(442));
    check("fast1_timing_errors", 72'(bad), 72'(0));

    // Reset wins over simultaneous start and write
    fast_reset = 1'b1; fast_start = 1'b1;
    fast_wr_en = 1'b1; fast_wr_addr = 2'd2; fast_wr_data = 24'h000000;
    tick();
    fast_reset = 1'b0; fast_start = 1'b0; fast_wr_en = 1'b0;
    check("fast_reset_over_start", 72'({fast_dout, fast_busy, fast_done}), 72'(3'b000));
    tick();
    check("fast_idle_after_reset", 72'(fast_busy), 72'(0));

    // Out-of-range write must not disturb the buffer
    fast_wr_en = 1'b1; fast_wr_addr = 2'd3; fast_wr_data = 24'hABCDEF;
    tick();
    fast_wr_en = 1'b0;
    run_fast(1'b0, bits, dk, bad);
    check("fast2_pixels", bits, {24'h00FF00, 24'hFFFFFF, 24'h123456});
    check("fast2_done_cycle", 72'(dk), 72'(442));
    check("fast2_timing_errors", 72'(bad), 72'(0));

`ifdef LED_BRIGHTNESS_EN
    fast_wr_en = 1'b1; fast_wr_addr = 2'd0; fast_wr_data = 24'hFF8040;
    bright = 8'h7F;
    tick();
    fast_wr_en = 1'b0;
    run_fast(1'b0, bits, dk, bad);
    check("fast3_scaled_pixel0", 72'(bits[71:48]), 72'(24'h7F4020));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/led_strip_driver.md
LED_STRIP_DRIVER -- requirements
Module: led_strip_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 64, giving the number of pixels per frame (range 1..1024).
REQ-002 SHALL have parameter T0H_CYC, default 16, giving the high time of a 0-bit in clk cycles.
REQ-003 SHALL have parameter T0L_CYC, default 34, giving the low time of a 0-bit in clk cycles.
REQ-004 SHALL have parameter T1H_CYC, default 32, giving the high time of a 1-bit in clk cycles.
REQ-005 SHALL have parameter T1L_CYC, default 18, giving the low time of a 1-bit in clk cycles.
REQ-006 SHALL have parameter RES_CYC, default 2000, giving the latch low time in clk cycles.
REQ-007 SHALL have port clk, input, width 1: clock.
REQ-008 SHALL have port reset, input, width 1: synchronous active-high reset.
REQ-009 SHALL have port wr_en, input, width 1: pixel buffer write strobe.
REQ-010 SHALL have port wr_addr, input, width $clog2(NUM_LEDS) (minimum 1): pixel index.
REQ-011 SHALL have port wr_data, input, width 24: pixel as {G[7:0],R[7:0],B[7:0]}.
REQ-012 SHALL have port start, input, width 1: request one frame transmission.
REQ-013 SHALL have port busy, output, width 1: frame in progress.
REQ-014 SHALL have port done, output, width 1: one-cycle end-of-frame pulse.
REQ-015 SHALL have port dout, output, width 1: WS2812B serial line, registered.

Function
REQ-016 SHALL hold an internal NUM_LEDS x 24 pixel buffer; a write with wr_en=1 updates it at the clk edge; wr_addr >= NUM_LEDS SHALL be ignored.
REQ-017 SHALL implement states IDLE, HIGH, LOW, LATCH; IDLE->HIGH on start, HIGH->LOW after high time, LOW->HIGH (next bit) or LOW->LATCH (last bit of last pixel), LATCH->IDLE after RES_CYC.
REQ-018 SHALL, when start=1 in IDLE, load pixel 0 into a 24-bit shift register, assert busy, and drive dout=1 starting the next cycle.
REQ-019 SHALL transmit each pixel MSB first (bit 23 = G7 ... bit 0 = B0), pixels in order 0..NUM_LEDS-1.
REQ-020 SHALL hold dout=1 for exactly T0H_CYC/T1H_CYC cycles and dout=0 for exactly T0L_CYC/T1L_CYC cycles per 0/1-bit.
REQ-021 SHALL sample pixel n+1 from the buffer in the last LOW cycle of bit 0 of pixel n; writes before that edge are transmitted, later writes wait for the next frame.
REQ-022 SHALL hold dout=0 for exactly RES_CYC cycles in LATCH, then pulse done for one cycle coincident with the return to IDLE, with busy=0 that cycle.
REQ-023 SHALL ignore start while busy=1, including during LATCH.
REQ-024 SHALL give a frame duration from start sample to done of NUM_LEDS*24*(bit period)+RES_CYC cycles, where bit period = T0H_CYC+T0L_CYC or T1H_CYC+T1L_CYC per bit.
REQ-025 SHALL size internal cycle counters to hold max(all timing parameters) without wrap.

Reset
REQ-026 SHALL, on reset=1, enter IDLE and force dout=0, busy=0, done=0 on the next cycle, including mid-frame, with no partial latch.
REQ-027 SHALL NOT clear pixel buffer contents on reset.
REQ-028 SHALL give reset priority over a simultaneous start or wr_en.

Configuration
REQ-029 SHALL, with macro LED_BRIGHTNESS_EN defined, add input bright[7:0] and transmit each 8-bit channel c as (c*(bright+1))>>8, with bright sampled at each pixel load.
REQ-030 SHALL, without LED_BRIGHTNESS_EN, omit port bright and transmit buffer contents unscaled.

Verification
REQ-031 SHALL verify: NUM_LEDS=1, pixel0=24'h800000, start -> dout high 32 cycles, low 18, then 23 bits each high 16 / low 34, then low 2000, then done.
REQ-032 SHALL verify: NUM_LEDS=64, all pixels 24'h000000, start -> done exactly 64*24*50+2000=78800 cycles after start sampled.
REQ-033 SHALL verify: start pulsed again at cycles 100 and 78790 of a frame -> ignored, exactly one done.
REQ-034 SHALL verify: reset at cycle 5000 of a frame -> dout=0, busy=0 next cycle; subsequent start sends the full frame from pixel 0.
REQ-035 SHALL verify: write pixel1=24'hFFFFFF during bit 10 of pixel0 -> pixel1 sent as all 1-bits; write at wr_addr=NUM_LEDS -> buffer unchanged.
REQ-036 SHALL verify: with LED_BRIGHTNESS_EN, bright=8'h7F and pixel 24'hFF8040 -> transmitted 24'h7F4020.
